// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the data-memory stage. One transaction is outstanding at a time, the
// memory-side request is held stable until mem_ack, and read data comes back
// on a registered one-cycle ready pulse. A data-grant streak counter bounds
// how long a pending fetch can be held off by back-to-back loads/stores.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  output logic [DW-1:0]     if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DW/8-1:0]   dm_be,
  input  logic [AW-1:0]     dm_addr,
  input  logic [DW-1:0]     dm_wdata,
  output logic [DW-1:0]     dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DW/8-1:0]   mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              owner
);

  localparam int BW = DW / 8;
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] DSTREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [SW-1:0] DSTREAK_ONE = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_WAIT = 2'd1,
    DM_WAIT = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [SW-1:0]   dstreak_q,   dstreak_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [BW-1:0]   mem_be_q,    mem_be_d;
  logic [AW-1:0]   mem_addr_q,  mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   if_rdata_q,  if_rdata_d;
  logic [DW-1:0]   dm_rdata_q,  dm_rdata_d;
  logic            if_ready_q,  if_ready_d;
  logic            dm_ready_q,  dm_ready_d;
  logic            busy_q,      busy_d;
  logic            owner_q,     owner_d;
  logic            fetch_wins_s;

  // Arbitration, grant capture and completion handling for the next cycle.
  always_comb begin
    state_d      = state_q;
    dstreak_d    = dstreak_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    owner_d      = owner_q;
    // Fetch wins when it is alone, or when data has used up its streak.
    fetch_wins_s = if_req && (!dm_req || (dstreak_q == DSTREAK_MAX));

    case (state_q)
      IDLE: begin
        if (fetch_wins_s) begin
          state_d     = IF_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = {BW{1'b1}};
          mem_addr_d  = if_addr;
          mem_wdata_d = {DW{1'b0}};
          owner_d     = 1'b0;
          dstreak_d   = {SW{1'b0}};
        end else if (dm_req) begin
          state_d     = DM_WAIT;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_be_d    = dm_we ? dm_be : {BW{1'b1}};
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          owner_d     = 1'b1;
          // Only a data grant that overtakes a waiting fetch counts.
          if (if_req && (dstreak_q != DSTREAK_MAX)) begin
            dstreak_d = dstreak_q + DSTREAK_ONE;
          end else begin
            dstreak_d = dstreak_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      IF_WAIT: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = IF_WAIT;
        end
      end
      DM_WAIT: begin
        if (mem_ack) begin
          // A store completes without disturbing the last load result.
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end else begin
            dm_rdata_d = dm_rdata_q;
          end
          dm_ready_d = 1'b1;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = DM_WAIT;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any outstanding transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      dstreak_q   <= {SW{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= {BW{1'b0}};
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      if_rdata_q  <= {DW{1'b0}};
      dm_rdata_q  <= {DW{1'b0}};
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dstreak_q   <= dstreak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two requester drivers, a behavioural memory
// with random latency, a grant/stability checker on the memory side and a
// scoreboard monitor on the ready outputs.
module tb_mem_port_arbiter;

  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        owner;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(MAXD)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard queues and reference state
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic        grant_log[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_last_load = 32'h0;

  // memory behaviour controls
  int unsigned lat_lo = 0;
  int unsigned lat_hi = 0;
  bit          ack_inhibit = 1'b0;
  bit          spurious_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  // ---------------- requester drivers ----------------
  task automatic present_fetch(input logic [31:0] addr, input logic [31:0] expv);
    if_addr = addr;
    if_req  = 1'b1;
    if_q.push_back(expv);
  endtask

  task automatic present_data(input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wd);
    dm_we    = we;
    dm_be    = be;
    dm_addr  = addr;
    dm_wdata = wd;
    dm_req   = 1'b1;
    if (we) begin
      ref_mem[addr] = merge(ref_read(addr), wd, be);
    end else begin
      ref_last_load = ref_read(addr);
    end
    dm_q.push_back(ref_last_load);
  endtask

  task automatic rand_data();
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    we   = 1'($urandom_range(0, 1));
    be   = 4'($urandom_range(1, 15));
    addr = 32'h0000_2000 + 32'(4 * $urandom_range(0, 15));
    present_data(we, be, addr, $urandom());
  endtask

  task automatic rand_fetch();
    logic [31:0] addr;
    addr = 32'h0000_1000 + 32'(4 * $urandom_range(0, 255));
    present_fetch(addr, init_val(addr));
  endtask

  task automatic wait_fetch(input bit drop);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!if_ready && t < 400);
    check("fetch_ready_seen", 64'(if_ready), 64'(1'b1));
    if (drop) if_req = 1'b0;
  endtask

  task automatic wait_data(input bit drop);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!dm_ready && t < 400);
    check("data_ready_seen", 64'(dm_ready), 64'(1'b1));
    if (drop) dm_req = 1'b0;
  endtask

  // ---------------- request snapshot at each active edge ----------------
  logic        snap_if_req, snap_dm_req, snap_dm_we;
  logic [31:0] snap_if_addr, snap_dm_addr, snap_dm_wdata;
  logic [3:0]  snap_dm_be;

  always @(posedge clk) begin
    snap_if_req   <= if_req;
    snap_if_addr  <= if_addr;
    snap_dm_req   <= dm_req;
    snap_dm_we    <= dm_we;
    snap_dm_be    <= dm_be;
    snap_dm_addr  <= dm_addr;
    snap_dm_wdata <= dm_wdata;
  end

  // ---------------- memory model and memory-side checker ----------------
  initial begin : memory
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we, cap_owner, exp_own;
    logic [3:0]  cap_be;
    bit          in_txn;
    int          cnt, streak;
    in_txn    = 1'b0;
    cnt       = 0;
    streak    = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom();
      if (!rst) begin
        in_txn = 1'b0;
        streak = 0;
      end else if (mem_req) begin
        if (!in_txn) begin
          // new grant: check arbitration rule and the captured request
          check("grant_had_request", 64'(snap_if_req | snap_dm_req), 64'(1'b1));
          if (snap_if_req && snap_dm_req) exp_own = (streak == MAXD) ? 1'b0 : 1'b1;
          else                             exp_own = snap_dm_req;
          check("grant_owner", 64'(owner), 64'(exp_own));
          check("busy_in_txn", 64'(busy), 64'(1'b1));
          if (exp_own) begin
            check("data_grant_req", 64'({mem_addr, mem_we, mem_be}),
                  64'({snap_dm_addr, snap_dm_we, (snap_dm_we ? snap_dm_be : 4'hF)}));
            if (snap_dm_we) check("store_wdata", 64'(mem_wdata), 64'(snap_dm_wdata));
            if (snap_if_req) streak = (streak < MAXD) ? streak + 1 : MAXD;
          end else begin
            check("fetch_grant_req", 64'({mem_addr, mem_we, mem_be}),
                  64'({snap_if_addr, 1'b0, 4'hF}));
            check("fetch_wdata_zero", 64'(mem_wdata), 64'(32'h0));
            streak = 0;
          end
          grant_log.push_back(owner);
          cap_addr  = mem_addr;
          cap_we    = mem_we;
          cap_be    = mem_be;
          cap_wdata = mem_wdata;
          cap_owner = owner;
          cnt       = int'($urandom_range(lat_hi, lat_lo));
          in_txn    = 1'b1;
        end else begin
          check("mem_side_stable", 64'({mem_addr, mem_we, mem_be, owner}),
                64'({cap_addr, cap_we, cap_be, cap_owner}));
          check("mem_wdata_stable", 64'(mem_wdata), 64'(cap_wdata));
        end
        if (cnt == 0 && !ack_inhibit) begin
          mem_ack = 1'b1;
          if (cap_we) dev_mem[cap_addr] = merge(dev_read(cap_addr), cap_wdata, cap_be);
          else        mem_rdata = dev_read(cap_addr);
          in_txn = 1'b0;
        end else if (cnt > 0) begin
          cnt--;
        end
      end else begin
        in_txn = 1'b0;
        if (spurious_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
      end
    end
  end

  // ---------------- ready monitor / scoreboard ----------------
  initial begin : monitor
    logic [31:0] last_if, last_dm, expv;
    last_if = 32'h0;
    last_dm = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        last_if = 32'h0;
        last_dm = 32'h0;
      end else begin
        if (if_ready) begin
          check("if_ready_has_pending", 64'(if_q.size() != 0), 64'(1'b1));
          if (if_q.size() != 0) begin
            expv = if_q.pop_front();
            check("if_rdata", 64'(if_rdata), 64'(expv));
            last_if = expv;
          end
        end else begin
          check("if_rdata_hold", 64'(if_rdata), 64'(last_if));
        end
        if (dm_ready) begin
          check("dm_ready_has_pending", 64'(dm_q.size() != 0), 64'(1'b1));
          if (dm_q.size() != 0) begin
            expv = dm_q.pop_front();
            check("dm_rdata", 64'(dm_rdata), 64'(expv));
            last_dm = expv;
          end
        end else begin
          check("dm_rdata_hold", 64'(dm_rdata), 64'(last_dm));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
    dev_mem[32'h0000_0040] = 32'h2008_0005;
    dev_mem[32'h0000_0100] = 32'h0;
    ref_mem[32'h0000_0100] = 32'h0;

    // reset held with both requests asserted
    @(negedge clk);
    present_fetch(32'h0000_1010, init_val(32'h0000_1010));
    present_data(1'b0, 4'hF, 32'h0000_2000, 32'h0);
    repeat (5) begin
      @(negedge clk);
      check("reset_ctrl", 64'({mem_req, mem_we, mem_be, if_ready, dm_ready, busy, owner}), 64'(10'h0));
      check("reset_addr_wdata", 64'({mem_addr, mem_wdata}), 64'h0);
      check("reset_rdata", 64'({if_rdata, dm_rdata}), 64'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("grant_after_reset", 64'({mem_req, owner}), 64'(2'b11));
    fork
      wait_data(1'b1);
      wait_fetch(1'b1);
    join

    // single fetch, memory acks after two extra cycles
    lat_lo = 2; lat_hi = 2;
    repeat (2) @(negedge clk);
    present_fetch(32'h0000_0040, 32'h2008_0005);
    wait_fetch(1'b1);
    check("single_fetch_rdata", 64'(if_rdata), 64'(32'h2008_0005));
    check("single_fetch_no_dm_ready", 64'(dm_ready), 64'(1'b0));
    @(negedge clk);
    check("if_ready_one_cycle", 64'(if_ready), 64'(1'b0));

    // store then load of the same word
    lat_lo = 0; lat_hi = 1;
    present_data(1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF);
    wait_data(1'b1);
    @(negedge clk);
    present_data(1'b0, 4'hF, 32'h0000_0100, 32'h0);
    wait_data(1'b1);
    check("load_after_store", 64'(dm_rdata), 64'(32'h0000_BEEF));

    // mid-transaction reset with a non-zero streak in flight
    lat_lo = 0; lat_hi = 0;
    @(negedge clk);
    present_fetch(32'h0000_1100, init_val(32'h0000_1100));
    present_data(1'b0, 4'hF, 32'h0000_2004, 32'h0);
    wait_data(1'b0);
    present_data(1'b0, 4'hF, 32'h0000_2008, 32'h0);
    wait_data(1'b0);
    ack_inhibit = 1'b1;
    present_data(1'b0, 4'hF, 32'h0000_200C, 32'h0);
    t = 0;
    while (!mem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("midreset_grant_seen", 64'({mem_req, owner}), 64'(2'b11));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_async_drop", 64'({mem_req, busy, dm_ready, if_ready}), 64'(4'h0));
    if_q.delete();
    dm_q.delete();
    ref_last_load = 32'h0;
    if_req = 1'b0;
    dm_req = 1'b0;
    ack_inhibit = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // contention after reset: streak must restart from zero
    lat_lo = 0; lat_hi = 3;
    grant_log.delete();
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          rand_fetch();
          wait_fetch(k == 1);
        end
      end
      begin
        for (int k = 0; k < 8; k++) begin
          rand_data();
          wait_data(k == 7);
        end
      end
    join
    check("contention_grant_count", 64'(grant_log.size()), 64'(10));
    for (int i = 0; i < 10; i++) begin
      logic g;
      g = (i < grant_log.size()) ? grant_log[i] : 1'bx;
      check($sformatf("contention_grant_%0d", i), 64'(g), 64'((i == 4 || i == 9) ? 1'b0 : 1'b1));
    end

    // randomized traffic with variable latency and spurious acks
    lat_lo = 0; lat_hi = 7;
    spurious_en = 1'b1;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          int gap;
          rand_fetch();
          wait_fetch(1'b0);
          gap = int'($urandom_range(0, 3));
          if (gap > 0 || k == 24) begin
            if_req = 1'b0;
            repeat (gap) @(negedge clk);
          end
        end
      end
      begin
        for (int k = 0; k < 35; k++) begin
          int gap;
          rand_data();
          wait_data(1'b0);
          gap = int'($urandom_range(0, 3));
          if (gap > 0 || k == 34) begin
            dm_req = 1'b0;
            repeat (gap) @(negedge clk);
          end
        end
      end
    join
    repeat (20) @(negedge clk);
    spurious_en = 1'b0;
    repeat (2) @(negedge clk);
    check("if_queue_drained", 64'(if_q.size()), 64'(0));
    check("dm_queue_drained", 64'(dm_q.size()), 64'(0));
    check("idle_at_end", 64'({busy, mem_req}), 64'(2'b00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
